// File: rtl/mod_pingpong_reader_if.sv
// Symbol stream from the ping-pong buffer reader to the transform precoder.
// The master drives I/Q/valid/last and the slave returns ready.
interface mod_pingpong_reader_if #(
  parameter int LUT_WIDTH = 18
);
  logic signed [LUT_WIDTH-1:0] Sym_I;
  logic signed [LUT_WIDTH-1:0] Sym_Q;
  logic                        Sym_Valid;
  logic                        Sym_Ready;
  logic                        Sym_Last;

  modport master (output Sym_I, Sym_Q, Sym_Valid, Sym_Last, input Sym_Ready);
  modport slave  (input Sym_I, Sym_Q, Sym_Valid, Sym_Last, output Sym_Ready);
endinterface

// File: rtl/mod_pingpong_reader.sv
// Read side of the mapper ping-pong symbol buffer: drains each completed bank in address
// order into a 2-entry output FIFO and hands the bank back to the writer after its last symbol.
module mod_pingpong_reader #(
  parameter int LUT_WIDTH  = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_SYMS   = 1200
) (
  input  logic                  CLK_Rd,
  input  logic                  RST_Rd,
  input  logic                  Bank_Done,
  input  logic [ADDR_WIDTH-1:0] Bank_Len,
  output logic                  Wr_bank,
  output logic                  Rd_en,
  output logic                  Rd_bank,
  output logic [ADDR_WIDTH-1:0] Rd_addr,
  input  logic [LUT_WIDTH-1:0]  Rd_data_I,
  input  logic [LUT_WIDTH-1:0]  Rd_data_Q,
  output logic                  Bank_Free,
  output logic                  Overflow,
  mod_pingpong_reader_if.master sym
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_RELEASE} state_t;

  localparam logic [ADDR_WIDTH-1:0] MaxLen = ADDR_WIDTH'(MAX_SYMS);
  localparam int EntW = 2 * LUT_WIDTH + 1;

  state_t                state_q, state_d;
  logic [1:0]            pending_q, pending_d;
  logic                  wr_bank_q, rd_bank_q, overflow_q;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, last_addr_q;
  logic                  inflight_q, inflight_last_q;
  logic                  wptr_q, rptr_q;
  logic [1:0]            count_q;

  logic                  done_acc, release_bank, push, pop, sym_valid, rd_space;
  logic                  rd_en, rd_last;
  logic [ADDR_WIDTH-1:0] len_clamped, cur_len;
  logic [2:0]            occupancy;
  logic [EntW-1:0]       head;

  assign done_acc     = Bank_Done && (pending_q != 2'd2);
  assign release_bank = (state_q == S_RELEASE);
  assign len_clamped  = (Bank_Len > MaxLen) ? MaxLen : Bank_Len;
  assign push         = inflight_q;
  assign sym_valid    = (count_q != 2'd0);
  assign pop          = sym_valid && sym.Sym_Ready;
  // Count the read already in flight so a stalled consumer never overflows the FIFO.
  assign occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_space     = (occupancy < 3'd2);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_len
      logic [ADDR_WIDTH-1:0] len_q;
      always_ff @(posedge CLK_Rd) begin
        if (RST_Rd)                               len_q <= '0;
        else if (done_acc && wr_bank_q == 1'(gi)) len_q <= len_clamped;
      end
    end
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [EntW-1:0] ent_q;
      always_ff @(posedge CLK_Rd) begin
        if (RST_Rd)                        ent_q <= '0;
        else if (push && wptr_q == 1'(gi)) ent_q <= {Rd_data_I, Rd_data_Q, inflight_last_q};
      end
    end
  endgenerate

  assign cur_len = rd_bank_q ? g_len[1].len_q : g_len[0].len_q;
  assign head    = rptr_q ? g_fifo[1].ent_q : g_fifo[0].ent_q;

  always_comb begin
    pending_d = pending_q;
    case ({done_acc, release_bank})
      2'b10:   pending_d = pending_q + 2'd1;
      2'b01:   pending_d = pending_q - 2'd1;
      default: pending_d = pending_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending_q != 2'd0) state_d = (cur_len == '0) ? S_RELEASE : S_READ;
      end
      S_READ: begin
        if (cur_len == '0) begin
          state_d = S_RELEASE;
        end else if (rd_space) begin
          rd_en = 1'b1;
          if (cnt_q == cur_len - ADDR_WIDTH'(1)) begin
            rd_last = 1'b1;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pop && head[0]) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        cnt_d   = '0;
        state_d = (pending_d != 2'd0) ? S_READ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_Rd) begin
    if (RST_Rd) begin
      state_q         <= S_IDLE;
      pending_q       <= 2'd0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      overflow_q      <= 1'b0;
      cnt_q           <= '0;
      last_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wptr_q          <= 1'b0;
      rptr_q          <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      cnt_q           <= cnt_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_last;
      if (done_acc)                          wr_bank_q   <= ~wr_bank_q;
      if (Bank_Done && pending_q == 2'd2)    overflow_q  <= 1'b1;
      if (release_bank)                      rd_bank_q   <= ~rd_bank_q;
      if (rd_en)                             last_addr_q <= cnt_q;
      if (push)                              wptr_q      <= ~wptr_q;
      if (pop)                               rptr_q      <= ~rptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign Wr_bank       = wr_bank_q;
  assign Rd_en         = rd_en;
  assign Rd_bank       = rd_bank_q;
  assign Rd_addr       = rd_en ? cnt_q : last_addr_q;
  assign Bank_Free     = release_bank;
  assign Overflow      = overflow_q;
  assign sym.Sym_I     = head[EntW-1:LUT_WIDTH+1];
  assign sym.Sym_Q     = head[LUT_WIDTH:1];
  assign sym.Sym_Valid = sym_valid;
  assign sym.Sym_Last  = sym_valid && head[0];

endmodule

// File: tb/tb_mod_pingpong_reader.sv
// Bench for mod_pingpong_reader: random buffer contents and consumer backpressure,
// checked against a bank-queue model of the expected read addresses and symbol stream.
`timescale 1ns/1ps
module tb_mod_pingpong_reader;
  localparam int LW = 18, AW = 11, MAXS = 1200;

  logic          clk = 1'b0;
  logic          rst, bank_done, wr_bank, rd_en, rd_bank, bank_free, overflow;
  logic [AW-1:0] bank_len, rd_addr;
  logic [LW-1:0] rd_data_i, rd_data_q;

  mod_pingpong_reader_if #(.LUT_WIDTH(LW)) sym_if ();

  mod_pingpong_reader #(.LUT_WIDTH(LW), .ADDR_WIDTH(AW), .MAX_SYMS(MAXS)) dut (
    .CLK_Rd(clk), .RST_Rd(rst), .Bank_Done(bank_done), .Bank_Len(bank_len),
    .Wr_bank(wr_bank), .Rd_en(rd_en), .Rd_bank(rd_bank), .Rd_addr(rd_addr),
    .Rd_data_I(rd_data_i), .Rd_data_Q(rd_data_q), .Bank_Free(bank_free),
    .Overflow(overflow), .sym(sym_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Symbol buffer model: one-cycle read latency
  logic [LW-1:0] ram_i [2][2048];
  logic [LW-1:0] ram_q [2][2048];
  always @(posedge clk) if (rd_en) begin
    rd_data_i <= ram_i[rd_bank][rd_addr];
    rd_data_q <= ram_q[rd_bank][rd_addr];
  end

  int compared = 0, mismatched = 0;
  int ready_mode = 0;
  int model_pending = 0;
  logic model_wr = 1'b0, model_ovf = 1'b0;
  logic [2*LW:0] exp_sym[$];
  logic [AW:0]   exp_rd[$];

  int issued = 0, accepted = 0, sym_cnt = 0, free_cnt = 0;
  int first_sym_cyc = -1, last_sym_cyc = -1, last_free_cyc = -1;
  logic prev_stall = 1'b0;
  logic [2*LW:0] prev_data = '0, mon_cur, mon_exp_sym;
  logic [AW:0] mon_exp_rd;

  wire [53:0] all_outs = {wr_bank, rd_en, rd_bank, rd_addr, sym_if.Sym_I, sym_if.Sym_Q,
                          sym_if.Sym_Valid, sym_if.Sym_Last, bank_free, overflow};

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    mon_cur = {sym_if.Sym_I, sym_if.Sym_Q, sym_if.Sym_Last};
    if (prev_stall) check("stall_hold", {sym_if.Sym_Valid, mon_cur}, {1'b1, prev_data});
    if (sym_if.Sym_Valid && first_sym_cyc < 0) first_sym_cyc = cyc;
    if (sym_if.Sym_Valid && sym_if.Sym_Ready) begin
      accepted++;
      sym_cnt++;
      last_sym_cyc = cyc;
      check("sym_expected", exp_sym.size() > 0, 1'b1);
      if (exp_sym.size() > 0) begin
        mon_exp_sym = exp_sym.pop_front();
        check("sym_data", mon_cur, mon_exp_sym);
      end
    end
    if (rd_en) begin
      issued++;
      check("rd_expected", exp_rd.size() > 0, 1'b1);
      if (exp_rd.size() > 0) begin
        mon_exp_rd = exp_rd.pop_front();
        check("rd_addr", {rd_bank, rd_addr}, mon_exp_rd);
      end
      check("rd_occupancy", (issued - accepted) <= 2, 1'b1);
    end
    if (bank_free) begin
      free_cnt++;
      last_free_cyc = cyc;
      model_pending--;
    end
    prev_stall = sym_if.Sym_Valid && !sym_if.Sym_Ready;
    prev_data  = mon_cur;
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       sym_if.Sym_Ready = 1'b1;
      1:       sym_if.Sym_Ready = ~sym_if.Sym_Ready;
      default: sym_if.Sym_Ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Writer model: an accepted bank queues its addresses and symbols; a third pending one is dropped
  task automatic issue_done(input int len, input int fill_mode, output int t0);
    int n;
    n = (len > MAXS) ? MAXS : len;
    if (model_pending < 2) begin
      for (int a = 0; a < n; a++) begin
        ram_i[model_wr][a] = (fill_mode == 0) ? LW'(a)  : LW'($urandom);
        ram_q[model_wr][a] = (fill_mode == 0) ? LW'(-a) : LW'($urandom);
        exp_rd.push_back({model_wr, AW'(a)});
        exp_sym.push_back({ram_i[model_wr][a], ram_q[model_wr][a], a == n - 1});
      end
      model_wr = ~model_wr;
      model_pending++;
    end else begin
      model_ovf = 1'b1;
    end
    bank_done = 1'b1;
    bank_len  = AW'(len);
    t0        = cyc;
    step();
    bank_done = 1'b0;
  endtask

  task automatic wait_free(input int target, input int budget);
    int b = 0;
    while (free_cnt < target && b < budget) begin
      step();
      b++;
    end
    check("bank_free_timeout", free_cnt >= target, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tmp, target, rd_before, sym_before, free_before, total, b;
    rst = 1'b1; bank_done = 1'b0; bank_len = '0;
    rd_data_i = '0; rd_data_q = '0; sym_if.Sym_Ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("reset_outputs", all_outs, 54'd0);
    step();
    rst = 1'b0;
    step();

    // 1) len 4, ramp data, consumer always ready
    first_sym_cyc = -1; sym_cnt = 0; target = free_cnt + 1;
    issue_done(4, 0, t0);
    wait_free(target, 50);
    check("t1_first_valid_cycle", first_sym_cyc, t0 + 4);
    check("t1_last_sym_cycle", last_sym_cyc, t0 + 7);
    check("t1_sym_count", sym_cnt, 4);
    check("t1_free_cycle", last_free_cyc, t0 + 8);
    @(negedge clk);
    check("t1_banks", {wr_bank, rd_bank}, {model_wr, model_wr});
    step();

    // 2) len 8 with toggling ready, then random lengths with random ready
    ready_mode = 1; sym_cnt = 0; target = free_cnt + 1;
    issue_done(8, 1, t0);
    wait_free(target, 200);
    check("t2_sym_count_toggle", sym_cnt, 8);
    ready_mode = 2; sym_cnt = 0; total = 0;
    for (int r = 0; r < 3; r++) begin
      target = free_cnt + 2;
      tmp = $urandom_range(1, 20); total += tmp;
      issue_done(tmp, 1, t0);
      step(); step();
      tmp = $urandom_range(1, 20); total += tmp;
      issue_done(tmp, 1, t0);
      wait_free(target, 500);
    end
    check("t2_sym_count_random", sym_cnt, total);
    check("t2_queues_empty", exp_sym.size() + exp_rd.size(), 0);
    ready_mode = 0;
    repeat (3) step();

    // 3) zero-length bank
    rd_before = issued; sym_before = sym_cnt; target = free_cnt + 1;
    issue_done(0, 0, t0);
    wait_free(target, 20);
    check("t3_free_cycle", last_free_cyc, t0 + 2);
    check("t3_no_rd_en", issued, rd_before);
    check("t3_no_symbols", sym_cnt, sym_before);
    @(negedge clk);
    check("t3_banks", {wr_bank, rd_bank}, {model_wr, model_wr});
    step();

    // 4) two banks pending, a dropped third, then clamped length
    sym_cnt = 0; target = free_cnt + 2;
    issue_done(1200, 1, t0);
    step(); step();
    issue_done(5, 1, t0);
    step(); step();
    issue_done(7, 1, t0);
    @(negedge clk);
    check("t4_overflow", overflow, model_ovf);
    check("t4_wr_bank_unchanged", wr_bank, model_wr);
    wait_free(target, 3000);
    check("t4_sym_count", sym_cnt, 1205);
    sym_cnt = 0; target = free_cnt + 1;
    issue_done(1500, 1, t0);
    wait_free(target, 2000);
    check("t4_clamped_count", sym_cnt, 1200);
    check("t4_queues_empty", exp_sym.size() + exp_rd.size(), 0);
    @(negedge clk);
    check("t4_overflow_sticky", overflow, 1'b1);
    step();

    // 5) reset in the middle of a bank, then a fresh bank
    sym_cnt = 0; free_before = free_cnt;
    issue_done(40, 1, t0);
    b = 0;
    while (sym_cnt < 10 && b < 100) begin step(); b++; end
    check("t5_reached_10", sym_cnt >= 10, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_sym.delete(); exp_rd.delete();
    model_pending = 0; model_wr = 1'b0; model_ovf = 1'b0;
    issued = 0; accepted = 0;
    @(negedge clk);
    check("t5_outputs_after_reset", all_outs, 54'd0);
    repeat (4) step();
    check("t5_no_bank_free", free_cnt, free_before);
    sym_cnt = 0; target = free_cnt + 1;
    issue_done(3, 0, t0);
    wait_free(target, 50);
    check("t5_sym_count", sym_cnt, 3);
    check("t5_queues_empty", exp_sym.size() + exp_rd.size(), 0);
    @(negedge clk);
    check("t5_banks", {wr_bank, rd_bank, overflow}, {model_wr, model_wr, model_ovf});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
